// File: rtl/write_resp_channel_mux_pkg.sv
// Shared interconnect definitions for the write-response return path:
// BRESP codes, the return-path FSM encoding and select decoding helpers.
package write_resp_channel_mux_pkg;

   localparam int SLAVES_NUM     = 2;
   localparam int SLAVES_ID_SIZE = $clog2(SLAVES_NUM);

   localparam logic [1:0] BRESP_OKAY   = 2'b00;
   localparam logic [1:0] BRESP_EXOKAY = 2'b01;
   localparam logic [1:0] BRESP_SLVERR = 2'b10;
   localparam logic [1:0] BRESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      WAIT_RESP = 2'b01,
      HOLD      = 2'b10
   } resp_state_t;

   // True when exactly one select bit is set.
   function automatic logic is_one_hot(input logic [SLAVES_NUM-1:0] sel);
      int unsigned ones;
      ones = 32'd0;
      for (int i = 0; i < SLAVES_NUM; i++) begin
         ones = ones + 32'(sel[i]);
      end
      return (ones == 32'd1);
   endfunction

   // Encodes a one-hot select into a slave index; only meaningful when one-hot.
   function automatic logic [SLAVES_ID_SIZE-1:0] one_hot_to_index(input logic [SLAVES_NUM-1:0] sel);
      logic [SLAVES_ID_SIZE-1:0] idx;
      idx = '0;
      for (int i = 0; i < SLAVES_NUM; i++) begin
         idx = idx | (sel[i] ? SLAVES_ID_SIZE'(i) : SLAVES_ID_SIZE'(0));
      end
      return idx;
   endfunction

   // True for the two error response codes.
   function automatic logic bresp_is_error(input logic [1:0] resp);
      return (resp == BRESP_SLVERR) || (resp == BRESP_DECERR);
   endfunction

   // True for the two success response codes.
   function automatic logic bresp_is_ok(input logic [1:0] resp);
      return (resp == BRESP_OKAY) || (resp == BRESP_EXOKAY);
   endfunction

endpackage

// File: rtl/write_resp_channel_mux_if.sv
// Bundle of AW-order, slave B and master B signals around the write response mux.
// The "slave" modport is the mux itself; "master" is the surrounding interconnect.
interface write_resp_channel_mux_if;
   import write_resp_channel_mux_pkg::*;

   logic                  AW_Push;
   logic [SLAVES_NUM-1:0] AW_Slave_Sel;
   logic                  Queue_Full;
   logic                  Sel_Error;

   logic [1:0]            M00_AXI_bresp;
   logic                  M00_AXI_bvalid;
   logic                  M00_AXI_bready;
   logic [1:0]            M01_AXI_bresp;
   logic                  M01_AXI_bvalid;
   logic                  M01_AXI_bready;

   logic [1:0]            Master_AXI_bresp;
   logic                  Master_AXI_bvalid;
   logic                  Master_AXI_bready;

   modport slave (
      input  AW_Push, AW_Slave_Sel,
      output Queue_Full, Sel_Error,
      input  M00_AXI_bresp, M00_AXI_bvalid,
      output M00_AXI_bready,
      input  M01_AXI_bresp, M01_AXI_bvalid,
      output M01_AXI_bready,
      output Master_AXI_bresp, Master_AXI_bvalid,
      input  Master_AXI_bready
   );

   modport master (
      output AW_Push, AW_Slave_Sel,
      input  Queue_Full, Sel_Error,
      output M00_AXI_bresp, M00_AXI_bvalid,
      input  M00_AXI_bready,
      output M01_AXI_bresp, M01_AXI_bvalid,
      input  M01_AXI_bready,
      input  Master_AXI_bresp, Master_AXI_bvalid,
      output Master_AXI_bready
   );

endinterface

// File: rtl/write_resp_channel_mux_id_order_fifo.sv
// Parameterised synchronous FIFO holding issue order (slave indices).
// Head is read combinationally from storage; full/empty are registered.
module id_order_fifo #(
   parameter  int WIDTH = 1,
   parameter  int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_next_s;
   logic             full_r;
   logic             empty_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Pointer advance with explicit wrap so non-power-of-two depths also work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   // Qualify push/pop; a push at full is taken only alongside a pop.
   always_comb begin
      do_pop_s     = pop & ~empty_r;
      do_push_s    = push & (~full_r | do_pop_s);
      count_next_s = count_r;
      if (do_push_s && !do_pop_s) begin
         count_next_s = count_r + CNT_W'(1);
      end else if (do_pop_s && !do_push_s) begin
         count_next_s = count_r - CNT_W'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // Storage, pointers, occupancy and registered flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r <= PTR_W'(0);
         rd_ptr_r <= PTR_W'(0);
         count_r  <= CNT_W'(0);
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         count_r <= count_next_s;
         full_r  <= (count_next_s == CNT_W'(DEPTH));
         empty_r <= (count_next_s == CNT_W'(0));
      end
   end

   assign dout  = mem_r[rd_ptr_r];
   assign full  = full_r;
   assign empty = empty_r;
   assign count = count_r;

endmodule

// File: rtl/write_resp_channel_mux.sv
// Write response return path: pops the AW issue-order queue, readies only
// the head slave, and presents its BRESP to the master from a register.
module write_resp_channel_mux
   import write_resp_channel_mux_pkg::*;
#(
   parameter int Slaves_Num        = SLAVES_NUM,
   parameter int Slaves_ID_Size    = SLAVES_ID_SIZE,
   parameter int Outstanding_Depth = 4
) (
   input logic                      ACLK,
   input logic                      ARESETN,
   write_resp_channel_mux_if.slave  bus
);

   localparam int CNT_W = $clog2(Outstanding_Depth + 1);

   resp_state_t               state_r;
   resp_state_t               state_next_s;
   logic                      sel_one_hot_s;
   logic                      push_s;
   logic                      pop_s;
   logic                      next_nonempty_s;
   logic [Slaves_ID_Size-1:0] push_idx_s;
   logic [Slaves_ID_Size-1:0] head_idx_s;
   logic                      fifo_full_s;
   logic                      fifo_empty_s;
   logic [CNT_W-1:0]          fifo_count_s;
   logic [Slaves_Num-1:0]     ready_s;
   logic [Slaves_Num-1:0]     slave_valid_s;
   logic [1:0]                head_resp_s;
   logic [1:0]                bresp_r;
   logic                      bvalid_r;
   logic                      sel_error_r;

   assign sel_one_hot_s = is_one_hot(bus.AW_Slave_Sel);
   assign push_s        = bus.AW_Push & sel_one_hot_s;
   assign push_idx_s    = one_hot_to_index(bus.AW_Slave_Sel);
   assign slave_valid_s = {bus.M01_AXI_bvalid, bus.M00_AXI_bvalid};

   id_order_fifo #(
      .WIDTH (Slaves_ID_Size),
      .DEPTH (Outstanding_Depth)
   ) u_id_fifo (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .push  (push_s),
      .pop   (pop_s),
      .din   (push_idx_s),
      .dout  (head_idx_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Head-slave ready, decoded from registered state and queue head only.
   always_comb begin
      ready_s = '0;
      if ((state_r == WAIT_RESP) && !fifo_empty_s) begin
         ready_s[head_idx_s] = 1'b1;
      end else begin
         ready_s = '0;
      end
   end

   // Select the response of the slave at the queue head.
   always_comb begin
      head_resp_s = bus.M00_AXI_bresp;
      if (head_idx_s == Slaves_ID_Size'(1)) begin
         head_resp_s = bus.M01_AXI_bresp;
      end else begin
         head_resp_s = bus.M00_AXI_bresp;
      end
   end

   assign pop_s = |(ready_s & slave_valid_s);
   // Outside WAIT_RESP nothing pops, so occupancy after this edge is count plus push.
   assign next_nonempty_s = (fifo_count_s != CNT_W'(0)) | push_s;

   // Next-state logic for the IDLE / WAIT_RESP / HOLD sequence.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (next_nonempty_s) begin
               state_next_s = WAIT_RESP;
            end else begin
               state_next_s = IDLE;
            end
         end
         WAIT_RESP: begin
            if (pop_s) begin
               state_next_s = HOLD;
            end else begin
               state_next_s = WAIT_RESP;
            end
         end
         HOLD: begin
            if (bus.Master_AXI_bready) begin
               state_next_s = next_nonempty_s ? WAIT_RESP : IDLE;
            end else begin
               state_next_s = HOLD;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register, master output stage and select-error flag.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_r     <= IDLE;
         bresp_r     <= BRESP_OKAY;
         bvalid_r    <= 1'b0;
         sel_error_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         bvalid_r    <= (state_next_s == HOLD);
         sel_error_r <= bus.AW_Push & ~sel_one_hot_s;
         if (pop_s) begin
            bresp_r <= head_resp_s;
         end
      end
   end

   assign bus.M00_AXI_bready    = ready_s[0];
   assign bus.M01_AXI_bready    = ready_s[1];
   assign bus.Master_AXI_bvalid = bvalid_r;
   assign bus.Master_AXI_bresp  = bresp_r;
   assign bus.Queue_Full        = fifo_full_s;
   assign bus.Sel_Error         = sel_error_r;

endmodule

// File: tb/tb_write_resp_channel_mux.sv
// Self-checking bench for write_resp_channel_mux: directed vector table,
// hand-written multi-cycle sequences and a randomized run against a
// transaction-level model (issue-order queue plus captured-response queue).
module tb_write_resp_channel_mux;
   import write_resp_channel_mux_pkg::*;

   logic ACLK;
   logic ARESETN;
   int   n_cmp;
   int   n_err;

   write_resp_channel_mux_if bus();

   write_resp_channel_mux #(
      .Slaves_Num        (2),
      .Slaves_ID_Size    (1),
      .Outstanding_Depth (4)
   ) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .bus     (bus)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct packed {
      logic       push;
      logic [1:0] sel;
      logic       v0;
      logic [1:0] r0;
      logic       v1;
      logic [1:0] r1;
      logic       mrdy;
      logic       e_rdy0;
      logic       e_rdy1;
      logic       e_mvalid;
      logic [1:0] e_mresp;
      logic       e_full;
      logic       e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic drive(input logic push, input logic [1:0] sel, input logic v0, input logic [1:0] r0,
                        input logic v1, input logic [1:0] r1, input logic mrdy);
      bus.AW_Push           = push;
      bus.AW_Slave_Sel      = sel;
      bus.M00_AXI_bvalid    = v0;
      bus.M00_AXI_bresp     = r0;
      bus.M01_AXI_bvalid    = v1;
      bus.M01_AXI_bresp     = r1;
      bus.Master_AXI_bready = mrdy;
   endtask

   // Random-phase model state.
   int         idq[$];
   logic [1:0] rq[$];
   bit         prev_bad;
   bit         sv[2];
   logic [1:0] sr[2];

   initial begin
      logic [1:0] exp_rdy;
      logic [1:0] shs;
      logic       mhs;
      logic       accept;
      logic       bad;
      logic       push;
      logic [1:0] sel;
      logic       mrdy;
      logic [1:0] exp_seq[5];
      int         guard;
      int         r;

      n_cmp = 0;
      n_err = 0;
      ARESETN = 1'b0;
      drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
      #1;
      check("reset_mvalid", bus.Master_AXI_bvalid, 1'b0);
      check("reset_mresp",  bus.Master_AXI_bresp, 2'b00);
      check("reset_full",   bus.Queue_Full, 1'b0);
      check("reset_err",    bus.Sel_Error, 1'b0);
      check("reset_rdy",    {bus.M01_AXI_bready, bus.M00_AXI_bready}, 2'b00);
      tick();
      tick();
      ARESETN = 1'b1;
      tick();

      // ---------------- directed vector table ----------------
      //                     push sel    v0   r0     v1   r1     mrdy  rdy0 rdy1 mv   mr     full err
      vecs.push_back(vec_t'{1'b1,2'b01,1'b0,2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b1,2'b00,1'b0,2'b00,1'b1, 1'b1,1'b0,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b1,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b1,2'b10,1'b0,2'b00,1'b0,2'b00,1'b0, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b1,2'b01,1'b1,2'b10,1'b0,2'b00,1'b0, 1'b0,1'b1,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b1,2'b10,1'b1,2'b10,1'b0,2'b00,1'b0, 1'b0,1'b1,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b1,2'b10,1'b1,2'b00,1'b0, 1'b0,1'b1,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b1,2'b10,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b1,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b1,2'b10,1'b0,2'b00,1'b1, 1'b1,1'b0,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b0,2'b00,1'b1,2'b00,1'b1, 1'b0,1'b0,1'b1,2'b10,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b0,2'b00,1'b1,2'b00,1'b1, 1'b0,1'b1,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b1,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b1,2'b11,1'b0,2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0});
      vecs.push_back(vec_t'{1'b1,2'b00,1'b0,2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b1});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b1});
      vecs.push_back(vec_t'{1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,1'b1, 1'b0,1'b0,1'b0,2'b00,1'b0,1'b0});

      for (int i = 0; i < vecs.size(); i++) begin
         check($sformatf("vec%0d_rdy0", i),   bus.M00_AXI_bready, vecs[i].e_rdy0);
         check($sformatf("vec%0d_rdy1", i),   bus.M01_AXI_bready, vecs[i].e_rdy1);
         check($sformatf("vec%0d_mvalid", i), bus.Master_AXI_bvalid, vecs[i].e_mvalid);
         if (vecs[i].e_mvalid) begin
            check($sformatf("vec%0d_mresp", i), bus.Master_AXI_bresp, vecs[i].e_mresp);
         end
         check($sformatf("vec%0d_full", i),   bus.Queue_Full, vecs[i].e_full);
         check($sformatf("vec%0d_err", i),    bus.Sel_Error, vecs[i].e_err);
         drive(vecs[i].push, vecs[i].sel, vecs[i].v0, vecs[i].r0, vecs[i].v1, vecs[i].r1, vecs[i].mrdy);
         tick();
      end
      drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);

      // ---------------- randomized run against the model ----------------
      prev_bad = 1'b0;
      sv[0] = 1'b0;
      sv[1] = 1'b0;
      sr[0] = 2'b00;
      sr[1] = 2'b00;
      for (int c = 0; c < 3200; c++) begin
         // The head slave is readied whenever entries are queued and no response is held.
         exp_rdy = (rq.size() == 0 && idq.size() > 0) ? (2'b01 << idq[0]) : 2'b00;
         check("rnd_rdy", {bus.M01_AXI_bready, bus.M00_AXI_bready}, exp_rdy);
         check("rnd_mvalid", bus.Master_AXI_bvalid, rq.size() != 0);
         if (rq.size() != 0) begin
            check("rnd_mresp", bus.Master_AXI_bresp, rq[0]);
         end
         check("rnd_full", bus.Queue_Full, idq.size() == 4);
         check("rnd_err", bus.Sel_Error, prev_bad);

         if (c < 3000) begin
            mrdy = ($urandom_range(0, 9) < 6);
            for (int k = 0; k < 2; k++) begin
               if (!sv[k] && $urandom_range(0, 1) == 1) begin
                  sv[k] = 1'b1;
                  sr[k] = 2'($urandom);
               end
            end
            push = ($urandom_range(0, 9) < 4);
            r = $urandom_range(0, 19);
            sel = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 11) ? 2'b01 : 2'b10;
            if (bus.Queue_Full && $urandom_range(0, 3) != 0) begin
               push = 1'b0;
            end
         end else begin
            mrdy = 1'b1;
            push = 1'b0;
            sel  = 2'b00;
            for (int k = 0; k < 2; k++) begin
               if (!sv[k]) begin
                  sv[k] = 1'b1;
                  sr[k] = 2'($urandom);
               end
            end
         end
         drive(push, sel, sv[0], sr[0], sv[1], sr[1], mrdy);

         shs    = exp_rdy & {sv[1], sv[0]};
         mhs    = (rq.size() != 0) && mrdy;
         accept = push && (sel == 2'b01 || sel == 2'b10) && (idq.size() < 4 || shs != 2'b00);
         bad    = push && !(sel == 2'b01 || sel == 2'b10);
         tick();

         if (shs != 2'b00) begin
            for (int k = 0; k < 2; k++) begin
               if (shs[k]) begin
                  rq.push_back(sr[k]);
                  sv[k] = 1'b0;
               end
            end
            void'(idq.pop_front());
         end
         if (mhs) begin
            void'(rq.pop_front());
         end
         if (accept) begin
            idq.push_back((sel == 2'b10) ? 1 : 0);
         end
         prev_bad = bad;
      end
      check("rnd_drained_ids", idq.size(), 0);
      check("rnd_drained_resp", rq.size(), 0);
      drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
      tick();
      tick();

      // ---------------- full queue: drop at full, push+pop at full ----------------
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
         tick();
      end
      check("full_after4", bus.Queue_Full, 1'b1);
      drive(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
      tick();
      check("full_drop5", bus.Queue_Full, 1'b1);
      drive(1'b1, 2'b10, 1'b1, BRESP_EXOKAY, 1'b0, 2'b00, 1'b0);
      tick();
      check("full_pushpop", bus.Queue_Full, 1'b1);
      check("full_pushpop_mvalid", bus.Master_AXI_bvalid, 1'b1);
      exp_seq[0] = BRESP_EXOKAY;
      exp_seq[1] = BRESP_EXOKAY;
      exp_seq[2] = BRESP_EXOKAY;
      exp_seq[3] = BRESP_EXOKAY;
      exp_seq[4] = BRESP_DECERR;
      drive(1'b0, 2'b00, 1'b1, BRESP_EXOKAY, 1'b1, BRESP_DECERR, 1'b1);
      for (int k = 0; k < 5; k++) begin
         guard = 0;
         while (!bus.Master_AXI_bvalid && guard < 20) begin
            tick();
            guard++;
         end
         if (!bus.Master_AXI_bvalid) begin
            check($sformatf("full_drain%0d_timeout", k), 32'd0, 32'd1);
         end else begin
            check($sformatf("full_drain%0d_resp", k), bus.Master_AXI_bresp, exp_seq[k]);
         end
         tick();
      end
      tick();
      tick();
      check("full_drain_mvalid", bus.Master_AXI_bvalid, 1'b0);
      check("full_drain_rdy", {bus.M01_AXI_bready, bus.M00_AXI_bready}, 2'b00);
      check("full_drain_full", bus.Queue_Full, 1'b0);
      drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
      tick();

      // ---------------- backpressure in HOLD ----------------
      drive(1'b1, 2'b01, 1'b1, BRESP_DECERR, 1'b0, 2'b00, 1'b0);
      tick();
      drive(1'b1, 2'b10, 1'b1, BRESP_DECERR, 1'b0, 2'b00, 1'b0);
      tick();
      drive(1'b1, 2'b01, 1'b1, BRESP_DECERR, 1'b0, 2'b00, 1'b0);
      tick();
      drive(1'b1, 2'b10, 1'b1, BRESP_DECERR, 1'b0, 2'b00, 1'b0);
      tick();
      drive(1'b0, 2'b00, 1'b1, BRESP_DECERR, 1'b0, 2'b00, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp%0d_mvalid", k), bus.Master_AXI_bvalid, 1'b1);
         check($sformatf("bp%0d_mresp", k), bus.Master_AXI_bresp, BRESP_DECERR);
         check($sformatf("bp%0d_rdy", k), {bus.M01_AXI_bready, bus.M00_AXI_bready}, 2'b00);
         check($sformatf("bp%0d_full", k), bus.Queue_Full, 1'b0);
         tick();
      end
      drive(1'b1, 2'b01, 1'b1, BRESP_DECERR, 1'b0, 2'b00, 1'b0);
      tick();
      drive(1'b0, 2'b00, 1'b1, BRESP_DECERR, 1'b0, 2'b00, 1'b0);
      check("bp_three_plus_one_full", bus.Queue_Full, 1'b1);
      check("bp_still_mvalid", bus.Master_AXI_bvalid, 1'b1);

      // ---------------- asynchronous reset while holding a response ----------------
      #2;
      ARESETN = 1'b0;
      #1;
      check("rst_hold_mvalid", bus.Master_AXI_bvalid, 1'b0);
      check("rst_hold_full", bus.Queue_Full, 1'b0);
      repeat (2) @(posedge ACLK);
      #2;
      ARESETN = 1'b1;
      tick();
      check("rst_after_mvalid", bus.Master_AXI_bvalid, 1'b0);
      check("rst_after_rdy", {bus.M01_AXI_bready, bus.M00_AXI_bready}, 2'b00);
      check("rst_after_full", bus.Queue_Full, 1'b0);
      check("rst_after_err", bus.Sel_Error, 1'b0);
      drive(1'b1, 2'b10, 1'b1, BRESP_DECERR, 1'b0, 2'b00, 1'b0);
      tick();
      drive(1'b0, 2'b00, 1'b1, BRESP_DECERR, 1'b1, BRESP_EXOKAY, 1'b1);
      check("rst_new_head_rdy", {bus.M01_AXI_bready, bus.M00_AXI_bready}, 2'b10);
      tick();
      check("rst_new_mvalid", bus.Master_AXI_bvalid, 1'b1);
      check("rst_new_mresp", bus.Master_AXI_bresp, BRESP_EXOKAY);
      tick();
      check("rst_queue_empty_rdy", {bus.M01_AXI_bready, bus.M00_AXI_bready}, 2'b00);
      check("rst_queue_empty_mvalid", bus.Master_AXI_bvalid, 1'b0);
      drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
